dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Parametrised data memory for the single-cycle/pipelined datapath. It replaces the fixed 64-word, word-only data RAM. It adds byte and halfword stores with lane enables, sign/zero-extended sub-word loads, alignment and range checking, a valid/ready request handshake and an optional zero-fill sequence after reset. It sits between the core's memory stage and the load/store writeback path.

## Interface
- ADDR_W, 6, word-address bits; depth = 2**ADDR_W 32-bit words
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response for the request accepted on the previous edge
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- rsp_err  out  1  request was misaligned, illegal size or out of range

## Operation
- Accept when req_valid && req_ready at a rising edge. There is no backpressure on the response side.
- Word index = req_addr[ADDR_W+1:2]. Lane = req_addr[1:0].
- In range when req_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- Error conditions:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - out of range
- On error: no array write, rsp_err=1, rsp_rdata=0.
- Store byte: req_wdata[7:0] goes to lane addr[1:0]. Store half: req_wdata[15:0] goes to lanes {addr[1],0},{addr[1],1}. Store word: all lanes. Unselected lanes are unchanged.
- Load: read the word and extract the lane. Extend bit 7 (byte) or bit 15 (half) unless req_unsigned. Word loads ignore req_unsigned.
- Little-endian: lane 0 = bits [7:0].
- FSM, two states:
  - CLEAR: req_ready=0. Clear counter walks 0..2**ADDR_W-1 writing 0, one word per cycle. Goes to IDLE after the last word.
  - IDLE: req_ready=1.
- The reset state is CLEAR (or IDLE if the feature is compiled out, see Configuration).

## Timing
- Reset values while rst_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM state = reset state, clear counter = 0.
- Latency is 1 cycle. A request accepted at edge N gives rsp_valid=1 during cycle N+1 with rdata/err valid. rsp_valid=0 the cycle after unless another request was accepted.
- One request per cycle, fully pipelined. Back-to-back accepts give back-to-back responses.
- Store at edge N, then a load of the same word at edge N+1: the load returns the stored data (array written at edge N). No stale data.
- Reads are synchronous (registered output). rsp_rdata holds its value when rsp_valid=0 is not required. It is driven to 0 on the cycle after a non-load.
- Clear sequence: with rst_n released before edge 0, words 0..D-1 are zeroed on edges 0..D-1. req_ready rises in the cycle after edge D-1, i.e. D cycles after reset release (D = 2**ADDR_W).
- Reset asserted mid-clear: the counter returns to 0 and the clear restarts from word 0.
- Reset asserted mid-response: rsp_valid drops immediately (asynchronous). The request is lost; whether its store landed depends on whether edge N occurred.
- req_valid during CLEAR is ignored. No store or response is generated.

## Configuration
- DMEM_CLEAR_EN defined: the reset state is CLEAR and the zero-fill runs as above. After reset, every word reads 0.
- DMEM_CLEAR_EN undefined:
  - No CLEAR state or counter. The reset state is IDLE.
  - req_ready=0 only while rst_n=0; it is 1 from the first edge after release.
  - Array contents after reset are undefined (X in simulation).
  - The bench must write before it reads.

## Test plan
- ADDR_W=6, DMEM_CLEAR_EN on: release reset. req_ready rises after exactly 64 cycles; a load at 0x00 returns 0, rsp_err=0.
- Store word 0xDEADBEEF @0x10, then store byte 0x5A @0x12. Then:
  - load word @0x10 returns 0xDE5ABEEF.
  - load byte signed @0x13 returns 0xFFFFFFDE.
  - load half unsigned @0x12 returns 0x0000DE5A.
- Back-to-back: store 0x12345678 @0x20 at edge N, load @0x20 at N+1. rsp_valid is high in cycles N+1 and N+2; rdata in N+2 is 0x12345678.
- Errors each give rsp_err=1, rdata=0 and leave the array unchanged (verified by a later load):
  - half store @0x21
  - word load @0x22
  - size 11
  - load @0x100 (out of range for ADDR_W=6, BASE 0)
- Pull rst_n low 20 cycles into the clear, then release. req_ready rises 64 cycles after the second release; rsp_valid stays 0 throughout.
- DMEM_CLEAR_EN off: req_ready=1 one cycle after reset release; store/load @0xFC round-trips 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane data memory with sub-word loads/stores, range/alignment checks, 1-cycle response.
// DMEM_CLEAR_EN: zero-fill every word after reset before accepting requests.
module dmem_bytelane #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [1:0]        lane;
    logic              clr_we;
    logic              acc;
    logic              err;
    logic              wr;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       rd_word;
    logic [7:0]        rd_b;
    logic [15:0]       rd_h;
    logic [31:0]       ld;

`ifdef DMEM_CLEAR_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    logic [0:0] state;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt)
                state <= IDLE;
        end
    assign req_ready = state == IDLE;
    assign clr_we    = state == CLEAR;
`else
    logic ready_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ready_q <= 1'b0;
        else
            ready_q <= 1'b1;
    assign req_ready = ready_q;
    assign clr_we    = 1'b0;
    assign clr_cnt   = '0;
`endif

    assign idx  = req_addr[ADDR_W+1:2];
    assign lane = req_addr[1:0];
    assign acc  = req_valid && req_ready;
    assign err  = req_size == 2'd3
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && lane != 2'd0)
               || req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
    assign wr   = acc && req_we && !err;

    always_comb begin
        be = req_size == 2'd0 ? 4'b0001 << lane :
             req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
             req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    end

    always_ff @(posedge clk)
        if (clr_we)
            mem[clr_cnt] <= '0;
        else if (wr)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];

    // Read sees the array before this edge's write, so a store at N is visible to a load at N+1.
    always_comb begin
        rd_word = mem[idx];
        rd_b    = rd_word[8*lane +: 8];
        rd_h    = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld      = req_size == 2'd0 ? {{24{~req_unsigned & rd_b[7]}}, rd_b} :
                  req_size == 2'd1 ? {{16{~req_unsigned & rd_h[15]}}, rd_h} : rd_word;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= acc;
            rsp_err   <= acc && err;
            rsp_rdata <= (acc && !req_we && !err) ? ld : 32'h0;
        end
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: directed self-checking bench for dmem_bytelane (ADDR_W=6, BASE 0).
module tb_dmem_bytelane;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    int          checks = 0;
    int          failures = 0;

    dmem_bytelane #(.ADDR_W(6), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        drive(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        logic saw_valid;
        n = 0;
        saw_valid = 1'b0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            saw_valid |= rsp_valid;
        end
        req_valid = 1'b0;
        chk({tag, ".cycles"}, n, exp_cycles);
        chk({tag, ".no_rsp"}, {31'b0, saw_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'b0, req_ready}, 32'd0);
        chk("rst.valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", {31'b0, rsp_err}, 32'd0);
`ifdef DMEM_CLEAR_EN
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        wait_ready("clear", 64);
        access("ld0", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
`else
        rst_n = 1'b1;
        chk("rel.ready0", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel.ready1", {31'b0, req_ready}, 32'd1);
        access("st_fc", 1'b1, 2'd2, 1'b0, 32'hFC, 32'hA5A5_A5A5, 32'h0, 1'b0);
        access("ld_fc", 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'hA5A5_A5A5, 1'b0);
`endif
        access("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("st_b12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_005A, 32'h0, 1'b0);
        access("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE5A_BEEF, 1'b0);
        access("ld_bs13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        access("ld_hu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_DE5A, 1'b0);
        access("ld_hs10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0);
        access("ld_bu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000_00BE, 1'b0);
        access("ld_w_uns", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'hDE5A_BEEF, 1'b0);

        // Back-to-back store then load of the same word.
        drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        chk("b2b.v1", {31'b0, rsp_valid}, 32'd1);
        drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b.v2", {31'b0, rsp_valid}, 32'd1);
        chk("b2b.rdata", rsp_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        chk("b2b.v3", {31'b0, rsp_valid}, 32'd0);

        access("e_half21", 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_FFFF, 32'h0, 1'b1);
        access("e_word22", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
        access("e_size3", 1'b1, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        access("e_ld100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        access("e_st110", 1'b1, 2'd2, 1'b0, 32'h110, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("chk_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
        access("chk_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE5A_BEEF, 1'b0);
        access("st_h22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_CAFE, 32'h0, 1'b0);
        access("ld_w20h", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFE_5678, 1'b0);
`ifdef DMEM_CLEAR_EN
        // Reset pulled 20 cycles into the clear restarts the zero-fill from word 0.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2.valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid.ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid.rst_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        wait_ready("reclear", 64);
        access("ld_w10_clr", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
